planar_fetch_ctrl: RTL
======================

PLANAR_FETCH_CTRL -- requirements
Module: planar_fetch_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset (see ports CLK and RST).
REQ-002 Parameter N_MAX, default 32: largest PU edge in samples.
REQ-003 Ports, in order (name, direction, width, meaning):
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  one-cycle request to fetch planar reference samples for one PU.
- PU  in  3  size code: 0=4, 1=8, 2=16, 3=32, 4-7 treated as 32.
- X  in  6  top-row start address.
- Y  in  6  left-column start address.
- TOP_RIGHT  in  8  top-right sample address.
- BOTTOM_LEFT  in  8  bottom-left sample address.
- RAM_GNT  in  1  shared neighbour-RAM grant from the arbiter for this cycle.
- RAM_RDATA  in  8  read data, valid one cycle after an issued read.
- RAM_REQ  out  1  request for the shared neighbour RAM.
- ADDRESS_RAM  out  8  read address.
- EN_TOP  out  1  read strobe, top RAM.
- EN_LEFT  out  1  read strobe, left RAM.
- SAMPLE_VALID  out  1  SAMPLE_DATA/SAMPLE_IDX valid.
- SAMPLE_DATA  out  8  fetched sample.
- SAMPLE_IDX  out  7  sample index.
- BUSY  out  1  fetch in progress.
- DONE  out  1  one-cycle completion pulse.

Function
REQ-004 Sample count SHALL be N = 4<<min(PU,3); total samples SHALL be 2N+2.
REQ-005 Every input SHALL be latched on the cycle START=1 and BUSY=0. START SHALL be ignored while BUSY=1.
REQ-006 The FSM SHALL have the states IDLE, TOP, TR, LEFT, BL, DRAIN and FIN.
- IDLE -> TOP on an accepted START.
- TOP -> TR after address X+N-1 is issued.
- TR -> LEFT after TOP_RIGHT is issued.
- LEFT -> BL after address Y+N-1 is issued.
- BL -> DRAIN after BOTTOM_LEFT is issued.
- DRAIN -> FIN after the final sample is returned.
- FIN -> IDLE unconditionally.
REQ-007 In TOP, TR, LEFT and BL, RAM_REQ SHALL be 1. A read SHALL be issued only in a cycle with RAM_GNT=1. In that cycle ADDRESS_RAM shows the address and exactly one enable is high: EN_TOP in TOP/TR, EN_LEFT in LEFT/BL.
REQ-008 When RAM_GNT=0, the controller SHALL hold state and address, keep both enables at 0, issue no read, and advance no counter.
REQ-009 Address sequence:
- TOP: X, X+1, ..., X+N-1.
- TR: TOP_RIGHT.
- LEFT: Y, ..., Y+N-1.
- BL: BOTTOM_LEFT.
- 8-bit arithmetic, zero-extended X/Y; maximum 94, so no wrap.
REQ-010 One cycle after each issued read, SAMPLE_VALID SHALL be 1, SAMPLE_DATA SHALL equal RAM_RDATA, and SAMPLE_IDX SHALL be:
- 0..N-1 for top samples;
- N for top-right;
- N+1..2N for left samples;
- 2N+1 for bottom-left.
REQ-011 Peak throughput SHALL be one read per cycle. With RAM_GNT held at 1, latency from START to DONE SHALL be 2N+4 cycles (START at cycle 0, DONE at cycle 2N+4).
REQ-012 DONE SHALL pulse for exactly one cycle, in FIN, which follows the last SAMPLE_VALID.
REQ-013 BUSY SHALL be 1 from the cycle after an accepted START through FIN inclusive. START in the FIN cycle SHALL be ignored.
REQ-014 In IDLE, DRAIN and FIN: RAM_REQ=0, EN_TOP=0, EN_LEFT=0.

Reset
REQ-015 While RST=1, all outputs SHALL be 0, the state SHALL be IDLE and the latched inputs SHALL be 0, independent of CLK.
REQ-016 RST asserted mid-fetch SHALL abort the fetch. After release no SAMPLE_VALID or DONE from the aborted job SHALL appear, and the first START is accepted normally.

Structure
REQ-017 A shared package planar_fetch_pkg SHALL hold:
- the state enumeration;
- PU code constants and the PU-to-N decode;
- sample-index width.
REQ-018 The address/index counter SHALL be one sub-module, fetch_addr_cnt, with load, enable and terminal-count outputs. All other logic SHALL be in planar_fetch_ctrl.

Verification
REQ-019 PU=0, X=8, Y=20, TOP_RIGHT=12, BOTTOM_LEFT=24, RAM_GNT=1 -> addresses 8,9,10,11,12,20,21,22,23,24. EN_TOP high for the first 5 reads, EN_LEFT for the last 5. SAMPLE_IDX 0..9. DONE at cycle 12.
REQ-020 PU=3, X=63, Y=62 -> top addresses 63..94 and left addresses 62..93. 66 samples. DONE at cycle 68.
REQ-021 PU=1, RAM_GNT=0 for 3 cycles mid-TOP -> no enables during the stall, no repeated or skipped address, DONE delayed by exactly 3 cycles.
REQ-022 START while BUSY=1, and START in the FIN cycle -> both ignored; only one DONE per accepted START.
REQ-023 RST pulse during LEFT of a PU=2 job, then new PU=0 START -> outputs 0 during reset, no stale samples, second job per REQ-019 timing.
REQ-024 PU=5 -> behaves identically to PU=3.

Source files
------------

// File: rtl/planar_fetch_pkg.sv
// Shared definitions for the planar reference-sample fetch controller:
// FSM states, PU size codes and the PU-to-edge-length decode.
package planar_fetch_pkg;

    localparam int unsigned IDX_W = 7;

    localparam logic [2:0] PU_4  = 3'd0;
    localparam logic [2:0] PU_8  = 3'd1;
    localparam logic [2:0] PU_16 = 3'd2;
    localparam logic [2:0] PU_32 = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOP,
        ST_TR,
        ST_LEFT,
        ST_BL,
        ST_DRAIN,
        ST_FIN
    } state_t;

    // Codes above PU_32 are reserved and decode as the largest PU.
    function automatic logic [IDX_W-1:0] pu_to_n(input logic [2:0] pu);
        case (pu)
            PU_4:    return 7'd4;
            PU_8:    return 7'd8;
            PU_16:   return 7'd16;
            default: return 7'd32;
        endcase
    endfunction

endpackage

// File: rtl/fetch_addr_cnt.sv
// Address/offset counter for one edge run; tc flags the last offset of the run.
module fetch_addr_cnt
    import planar_fetch_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [7:0]       load_addr,
    input  logic             en,
    input  logic [IDX_W-1:0] last,
    output logic [7:0]       addr,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= load_addr;
            cnt  <= '0;
        end else if (en) begin
            addr <= addr + 8'd1;
            cnt  <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/planar_fetch_ctrl.sv
// Fetches the 2N+2 planar reference samples of one PU (top row, top-right,
// left column, bottom-left) through the shared neighbour RAM, one read per grant.
module planar_fetch_ctrl
    import planar_fetch_pkg::*;
#(
    parameter int N_MAX = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       PU,
    input  logic [5:0]       X,
    input  logic [5:0]       Y,
    input  logic [7:0]       TOP_RIGHT,
    input  logic [7:0]       BOTTOM_LEFT,
    input  logic             RAM_GNT,
    input  logic [7:0]       RAM_RDATA,
    output logic             RAM_REQ,
    output logic [7:0]       ADDRESS_RAM,
    output logic             EN_TOP,
    output logic             EN_LEFT,
    output logic             SAMPLE_VALID,
    output logic [7:0]       SAMPLE_DATA,
    output logic [IDX_W-1:0] SAMPLE_IDX,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [IDX_W-1:0] N_LIM = IDX_W'(N_MAX);

    state_t           state, state_nx;
    logic [IDX_W-1:0] n_q, n_sel;
    logic [7:0]       y_q, tr_q, bl_q;
    logic             accept, issue;
    logic             cnt_load, cnt_en, cnt_tc;
    logic [7:0]       cnt_load_addr, cnt_addr;
    logic [IDX_W-1:0] cnt_val, idx_nx;
    logic             samp_valid_q;
    logic [IDX_W-1:0] samp_idx_q;

    fetch_addr_cnt u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .load      (cnt_load),
        .load_addr (cnt_load_addr),
        .en        (cnt_en),
        .last      (n_q - 1'b1),
        .addr      (cnt_addr),
        .cnt       (cnt_val),
        .tc        (cnt_tc)
    );

    always_comb begin
        n_sel = pu_to_n(PU);
        if (n_sel > N_LIM) n_sel = N_LIM;
    end

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        issue         = 1'b0;
        cnt_load      = 1'b0;
        cnt_load_addr = '0;
        cnt_en        = 1'b0;
        idx_nx        = '0;
        RAM_REQ       = 1'b0;
        ADDRESS_RAM   = '0;
        EN_TOP        = 1'b0;
        EN_LEFT       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    accept        = 1'b1;
                    cnt_load      = 1'b1;
                    cnt_load_addr = {2'b00, X};
                    state_nx      = ST_TOP;
                end
            end
            ST_TOP: begin
                RAM_REQ     = 1'b1;
                ADDRESS_RAM = cnt_addr;
                if (RAM_GNT) begin
                    issue  = 1'b1;
                    EN_TOP = 1'b1;
                    cnt_en = 1'b1;
                    idx_nx = cnt_val;
                    if (cnt_tc) state_nx = ST_TR;
                end
            end
            ST_TR: begin
                RAM_REQ     = 1'b1;
                ADDRESS_RAM = tr_q;
                if (RAM_GNT) begin
                    issue         = 1'b1;
                    EN_TOP        = 1'b1;
                    idx_nx        = n_q;
                    cnt_load      = 1'b1;
                    cnt_load_addr = y_q;
                    state_nx      = ST_LEFT;
                end
            end
            ST_LEFT: begin
                RAM_REQ     = 1'b1;
                ADDRESS_RAM = cnt_addr;
                if (RAM_GNT) begin
                    issue   = 1'b1;
                    EN_LEFT = 1'b1;
                    cnt_en  = 1'b1;
                    idx_nx  = n_q + 1'b1 + cnt_val;
                    if (cnt_tc) state_nx = ST_BL;
                end
            end
            ST_BL: begin
                RAM_REQ     = 1'b1;
                ADDRESS_RAM = bl_q;
                if (RAM_GNT) begin
                    issue    = 1'b1;
                    EN_LEFT  = 1'b1;
                    idx_nx   = {n_q[IDX_W-2:0], 1'b1};
                    state_nx = ST_DRAIN;
                end
            end
            // The bottom-left sample returns in this cycle, so drain is one cycle.
            ST_DRAIN: state_nx = ST_FIN;
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            n_q          <= '0;
            y_q          <= '0;
            tr_q         <= '0;
            bl_q         <= '0;
            samp_valid_q <= 1'b0;
            samp_idx_q   <= '0;
        end else begin
            state        <= state_nx;
            samp_valid_q <= issue;
            samp_idx_q   <= issue ? idx_nx : '0;
            if (accept) begin
                n_q  <= n_sel;
                y_q  <= {2'b00, Y};
                tr_q <= TOP_RIGHT;
                bl_q <= BOTTOM_LEFT;
            end
        end
    end

    assign SAMPLE_VALID = samp_valid_q;
    assign SAMPLE_DATA  = samp_valid_q ? RAM_RDATA : '0;
    assign SAMPLE_IDX   = samp_idx_q;
    assign BUSY         = (state != ST_IDLE);
    assign DONE         = (state == ST_FIN);

endmodule
